// File: rtl/layer_spike_scheduler_pkg.sv
// ============================================================================
// Module   : layer_sched_pkg
// Purpose  : Shared types and constants for the layer spike scheduler:
//            the sequencer state enum, the setup down-counter width and a
//            helper that sizes index/pointer fields.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package layer_sched_pkg;

  // Width of the ROM settle down-counter; covers setup_cycles 0..15.
  localparam int SETUP_CNT_W = 4;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETUP   = 3'd1,
    BCAST   = 3'd2,
    RELEASE = 3'd3,
    ACK     = 3'd4,
    DONE    = 3'd5
  } sched_state_t;

  // Bits needed to hold an index 0..n-1; never less than one bit so that a
  // single-requester build still has a legal (constant-zero) pointer.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/layer_spike_scheduler_if.sv
// ============================================================================
// Module   : layer_spike_scheduler_if
// Purpose  : Bundles the requester-side and neuron-side handshake signals of
//            the layer spike scheduler.
// Signals  : req_in   - per-input spike request (4-phase)
//            ack_in   - per-input acknowledge, at most one bit high
//            rom_addr - one-hot weight ROM row select, zero when idle
//            req_out  - broadcast request to all neurons
//            ack_out  - per-neuron acknowledge
//            busy     - scheduler is not idle
// Modports : master - scheduler side (drives ack_in/rom_addr/req_out/busy)
//            slave  - environment side (drives req_in/ack_out)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface layer_spike_scheduler_if #(
  parameter int NEURONS_IN  = 4,
  parameter int NEURONS_OUT = 8
);

  logic [NEURONS_IN-1:0]  req_in;
  logic [NEURONS_IN-1:0]  ack_in;
  logic [NEURONS_IN-1:0]  rom_addr;
  logic                   req_out;
  logic [NEURONS_OUT-1:0] ack_out;
  logic                   busy;

  modport master (
    input  req_in,
    input  ack_out,
    output ack_in,
    output rom_addr,
    output req_out,
    output busy
  );

  modport slave (
    output req_in,
    output ack_out,
    input  ack_in,
    input  rom_addr,
    input  req_out,
    input  busy
  );

endinterface

`default_nettype wire

// File: rtl/layer_spike_scheduler_arb.sv
// ============================================================================
// Module   : rr_arbiter_onehot
// Purpose  : Combinational round-robin picker. Searches the request vector
//            starting at i_ptr and wrapping, and returns the first pending
//            request as a one-hot grant plus its binary index.
// Ports    : i_req   - request vector
//            i_ptr   - index with highest priority this cycle
//            o_gnt   - one-hot grant (zero when nothing is pending)
//            o_idx   - binary index of the granted bit
//            o_valid - at least one request is pending
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter_onehot
  import layer_sched_pkg::*;
#(
  parameter int N     = 4,
  parameter int IDX_W = idx_w(N)
) (
  input  wire logic [N-1:0]     i_req,
  input  wire logic [IDX_W-1:0] i_ptr,
  output logic      [N-1:0]     o_gnt,
  output logic      [IDX_W-1:0] o_idx,
  output logic                  o_valid
);

  logic [IDX_W-1:0] w_idx;

  // Walk the candidates in priority order ptr, ptr+1, ... (mod N); the first
  // pending one wins and later candidates are masked by o_valid.
  always_comb begin
    o_gnt   = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    w_idx   = '0;
    for (int k = 0; k < N; k++) begin
      w_idx = IDX_W'((int'(i_ptr) + k) % N);
      if (!o_valid && i_req[w_idx]) begin
        o_valid      = 1'b1;
        o_gnt[w_idx] = 1'b1;
        o_idx        = w_idx;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/layer_spike_scheduler.sv
// ============================================================================
// Module   : layer_spike_scheduler
// Purpose  : Shares one layer's weight ROM and neuron bank between the input
//            spike requesters. Grants a pending request round-robin, drives
//            the one-hot ROM row, waits SETUP_CYCLES for the ROM to settle,
//            broadcasts req_out to every neuron, collects all neuron acks and
//            finishes the 4-phase handshake with the granted requester.
// Ports    : clk         - rising-edge clock
//            rst         - asynchronous active-high reset
//            spike_count - completed dispatches (LAYER_SPIKE_CNT_EN only)
//            bus         - handshake interface, master modport
// Macro    : LAYER_SPIKE_CNT_EN - adds the CNT_W-bit spike_count port and
//            its counter; absent otherwise.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module layer_spike_scheduler
  import layer_sched_pkg::*;
#(
  parameter int NEURONS_IN   = 4,
  parameter int NEURONS_OUT  = 8,
  parameter int SETUP_CYCLES = 2
`ifdef LAYER_SPIKE_CNT_EN
  ,
  parameter int CNT_W        = 16
`endif
) (
  input  wire logic clk,
  input  wire logic rst,
`ifdef LAYER_SPIKE_CNT_EN
  output logic [CNT_W-1:0] spike_count,
`endif
  layer_spike_scheduler_if.master bus
);

  localparam int IDX_W = idx_w(NEURONS_IN);

  // Counter preload on the grant edge; with SETUP_CYCLES == 0 the SETUP
  // state is skipped and this value is never consumed.
  localparam logic [SETUP_CNT_W-1:0] c_SETUP_LOAD =
    SETUP_CNT_W'((SETUP_CYCLES > 0) ? SETUP_CYCLES - 1 : 0);
  localparam sched_state_t c_GRANT_NEXT = (SETUP_CYCLES == 0) ? BCAST : SETUP;

  sched_state_t            r_state;
  logic [IDX_W-1:0]        r_ptr;
  logic [NEURONS_IN-1:0]   r_gnt;
  logic [IDX_W-1:0]        r_gnt_idx;
  logic [NEURONS_IN-1:0]   r_rom_addr;
  logic                    r_req_out;
  logic [NEURONS_IN-1:0]   r_ack_in;
  logic [SETUP_CNT_W-1:0]  r_setup_cnt;

  sched_state_t            w_state_nxt;
  logic [IDX_W-1:0]        w_ptr_nxt;
  logic [NEURONS_IN-1:0]   w_gnt_nxt;
  logic [IDX_W-1:0]        w_gnt_idx_nxt;
  logic [NEURONS_IN-1:0]   w_rom_addr_nxt;
  logic                    w_req_out_nxt;
  logic [NEURONS_IN-1:0]   w_ack_in_nxt;
  logic [SETUP_CNT_W-1:0]  w_setup_cnt_nxt;

  logic [NEURONS_IN-1:0]   w_arb_gnt;
  logic [IDX_W-1:0]        w_arb_idx;
  logic                    w_arb_valid;

  rr_arbiter_onehot #(
    .N     (NEURONS_IN),
    .IDX_W (IDX_W)
  ) u_arb (
    .i_req   (bus.req_in),
    .i_ptr   (r_ptr),
    .o_gnt   (w_arb_gnt),
    .o_idx   (w_arb_idx),
    .o_valid (w_arb_valid)
  );

  // --------------------------------------------------------------------------
  // State and output registers. All handshake outputs are registered so the
  // ROM and neurons never see combinational glitches.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_ptr       <= '0;
      r_gnt       <= '0;
      r_gnt_idx   <= '0;
      r_rom_addr  <= '0;
      r_req_out   <= 1'b0;
      r_ack_in    <= '0;
      r_setup_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_ptr       <= w_ptr_nxt;
      r_gnt       <= w_gnt_nxt;
      r_gnt_idx   <= w_gnt_idx_nxt;
      r_rom_addr  <= w_rom_addr_nxt;
      r_req_out   <= w_req_out_nxt;
      r_ack_in    <= w_ack_in_nxt;
      r_setup_cnt <= w_setup_cnt_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and next-output logic.
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt     = r_state;
    w_ptr_nxt       = r_ptr;
    w_gnt_nxt       = r_gnt;
    w_gnt_idx_nxt   = r_gnt_idx;
    w_rom_addr_nxt  = r_rom_addr;
    w_req_out_nxt   = r_req_out;
    w_ack_in_nxt    = r_ack_in;
    w_setup_cnt_nxt = r_setup_cnt;

    case (r_state)
      IDLE: begin
        // The grant is latched here and held until DONE, so later changes on
        // req_in cannot move the ROM row mid-transaction.
        if (w_arb_valid) begin
          w_gnt_nxt       = w_arb_gnt;
          w_gnt_idx_nxt   = w_arb_idx;
          w_rom_addr_nxt  = w_arb_gnt;
          w_setup_cnt_nxt = c_SETUP_LOAD;
          w_req_out_nxt   = (SETUP_CYCLES == 0);
          w_state_nxt     = c_GRANT_NEXT;
        end
      end

      SETUP: begin
        // Neuron acks are deliberately not looked at while the ROM settles.
        if (r_setup_cnt == '0) begin
          w_req_out_nxt = 1'b1;
          w_state_nxt   = BCAST;
        end else begin
          w_setup_cnt_nxt = r_setup_cnt - 1'b1;
        end
      end

      BCAST: begin
        // Wait for every neuron; partial acks simply hold the broadcast.
        if (&bus.ack_out) begin
          w_req_out_nxt = 1'b0;
          w_state_nxt   = RELEASE;
        end
      end

      RELEASE: begin
        if (~|bus.ack_out) begin
          w_ack_in_nxt   = r_gnt;
          w_rom_addr_nxt = '0;
          w_state_nxt    = ACK;
        end
      end

      ACK: begin
        // A requester that dropped early is already low, so this passes at
        // once and the sequence still completes.
        if ((bus.req_in & r_gnt) == '0) begin
          w_ack_in_nxt = '0;
          w_state_nxt  = DONE;
        end
      end

      DONE: begin
        w_ptr_nxt   = (r_gnt_idx == IDX_W'(NEURONS_IN - 1)) ? '0 : r_gnt_idx + 1'b1;
        w_state_nxt = IDLE;
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign bus.rom_addr = r_rom_addr;
  assign bus.req_out  = r_req_out;
  assign bus.ack_in   = r_ack_in;
  assign bus.busy     = (r_state != IDLE);

`ifdef LAYER_SPIKE_CNT_EN
  // --------------------------------------------------------------------------
  // Completed-dispatch counter; wraps naturally at 2^CNT_W.
  // --------------------------------------------------------------------------
  logic [CNT_W-1:0] r_spike_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_spike_count <= '0;
    end else if (r_state == DONE) begin
      r_spike_count <= r_spike_count + 1'b1;
    end
  end

  assign spike_count = r_spike_count;
`endif

  // --------------------------------------------------------------------------
  // Protocol properties.
  // --------------------------------------------------------------------------
  a_ack_in_onehot0 : assert property (@(posedge clk) disable iff (rst)
    $onehot0(r_ack_in));

  a_rom_addr_stable : assert property (@(posedge clk) disable iff (rst)
    r_req_out |=> $stable(r_rom_addr));

endmodule

`default_nettype wire
